md_frame_sequencer: RTL
=======================

// Module: md_frame_sequencer
// PURPOSE
//  Frame-level controller for the motion-detection datapath.
//  - Issues the pixel read strobe that drives the two frame-buffer reads and the detector's Read input.
//  - Generates raster X/Y coordinates and the region-of-interest (ROI) flag for the overlay mux.
//  - Counts detector hits per frame and raises a held motion alarm.
//  - Sits between the LCD timing domain and the detector; all logic is on LCD_CTRL_CLK.
// PARAMETERS
//  H_ACTIVE    800   active pixels per line
//  H_BLANK     256   blank cycles per line (line total = H_ACTIVE+H_BLANK)
//  V_ACTIVE    480   active lines per frame
//  V_BLANK     45    blank lines per frame
//  ROI_X0/X1   20/780  ROI columns, X0 <= x < X1
//  ROI_Y0/Y1   20/460  ROI rows, Y0 <= y < Y1
//  DET_LAT     7     cycles from oRead to matching iMOTION (range 1..64)
//  CNT_THRESH  64    per-frame hit count that triggers the alarm
//  HOLD_FRAMES 30    frames the alarm stays high after the last trigger (1..255)
//  TONE_DIV    2048  half-period of the speaker tone, in clocks
// PORTS
//  LCD_CTRL_CLK   in   1   pixel clock
//  iRST_N         in   1   asynchronous, active-low reset
//  iENABLE        in   1   run request (level)
//  iMOTION        in   1   detector hit (Y|Z), lags oRead by DET_LAT
//  oRead          out  1   pixel read strobe, high on active pixels only
//  oX             out  11  column of the current oRead pixel, 0..H_ACTIVE-1
//  oY             out  10  row of the current oRead pixel, 0..V_ACTIVE-1
//  oROI           out  1   current pixel is inside the ROI (aligned with oRead)
//  oFRAME_START   out  1   one-cycle pulse with the first oRead of a frame
//  oMOTION_CNT    out  19  hit count of the last completed frame
//  oCNT_VLD       out  1   one-cycle pulse when oMOTION_CNT updates
//  oALARM         out  1   motion alarm (held)
//  oSPK           out  1   speaker drive (MD_SPEAKER_EN only)
// BEHAVIOUR
//  Reset (async, any time, including mid-frame):
//  - All outputs 0; hold counter, hit counter and raster counters 0; FSM returns to IDLE.
//  FSM states and transitions:
//  - IDLE   -> VBLANK when iENABLE=1. Entry starts from VBLANK line 0, so the first frame is never partial.
//  - VBLANK -> ACTIVE after V_BLANK full lines, at y=0, x=0.
//  - ACTIVE -> HBLANK after H_ACTIVE cycles. oRead=1 for every cycle in ACTIVE.
//  - HBLANK -> ACTIVE after H_BLANK cycles (next line); after the last line, -> VBLANK.
//  - At VBLANK exit: if iENABLE=0, -> IDLE instead of ACTIVE. A frame in progress always completes.
//  Outputs in ACTIVE:
//  - oX/oY/oROI are registered outputs that change in the same cycle as oRead.
//  - oX/oY hold their last value outside ACTIVE; oROI=0 outside ACTIVE.
//  - oFRAME_START=1 at x=0, y=0.
//  Hit counting:
//  - oROI is delayed DET_LAT cycles (shift register) to roi_d.
//  - Hit counter increments on roi_d & iMOTION. It cannot overflow (max 760*440 < 2^19).
//  Evaluation (EVAL):
//  - One cycle at VBLANK line 0, cycle DET_LAT+1.
//  - oMOTION_CNT <= hit counter; oCNT_VLD=1; hit counter cleared in the same cycle.
//  - Any hit arriving in that cycle is dropped; none is possible when DET_LAT < H_BLANK.
//  Alarm hold, evaluated at EVAL:
//  - If count >= CNT_THRESH, hold <= HOLD_FRAMES.
//  - Else if hold != 0, hold <= hold-1.
//  - oALARM = (hold != 0), registered.
//  - A retrigger while the alarm is high reloads the hold; it does not accumulate.
//  IDLE:
//  - oRead=0 and no EVAL occurs.
//  - oALARM holds its last value (hold counter frozen) until the next EVAL.
// CONFIGURATION
//  MD_SPEAKER_EN defined:
//  - A free-running counter toggles a tone every TONE_DIV clocks.
//  - oSPK = tone & oALARM.
//  MD_SPEAKER_EN undefined:
//  - Tone counter not built; oSPK tied 0.
// TESTING
//  - Reset, then iENABLE=1 -> first oFRAME_START after 45*1056 clocks; exactly 800 oRead per line, 480 lines.
//  - iMOTION=1 constantly -> oMOTION_CNT=334400 (760*440) with oCNT_VLD once per frame.
//  - 64 hits inside ROI in frame N, 0 in all later frames -> oALARM rises at EVAL of N;
//    it falls at EVAL of N+30. 63 hits -> oALARM stays 0.
//  - 500 hits only at x<20 -> oMOTION_CNT=0 and oALARM=0 (ROI gating with DET_LAT alignment).
//  - iENABLE drops mid-frame -> frame completes with 384000 oRead; FSM enters IDLE at VBLANK exit.
//  - iRST_N pulsed low mid-line -> all outputs 0 in the same cycle; restart waits a full VBLANK.
//    With MD_SPEAKER_EN defined, oSPK toggles every 2048 clocks while oALARM=1.

Source files
------------

// File: rtl/md_frame_sequencer_if.sv
// Pixel-side bus of the motion-detection frame sequencer: run/motion inputs
// plus raster, ROI, per-frame count and alarm outputs.
interface md_frame_sequencer_if;
   logic        iENABLE;
   logic        iMOTION;
   logic        oRead;
   logic [10:0] oX;
   logic [9:0]  oY;
   logic        oROI;
   logic        oFRAME_START;
   logic [18:0] oMOTION_CNT;
   logic        oCNT_VLD;
   logic        oALARM;
   logic        oSPK;

   modport master (
      input  iENABLE, iMOTION,
      output oRead, oX, oY, oROI, oFRAME_START,
             oMOTION_CNT, oCNT_VLD, oALARM, oSPK
   );

   modport slave (
      output iENABLE, iMOTION,
      input  oRead, oX, oY, oROI, oFRAME_START,
             oMOTION_CNT, oCNT_VLD, oALARM, oSPK
   );
endinterface

// File: rtl/md_frame_sequencer.sv
// Frame-level raster/ROI sequencer with per-frame hit counting and a held alarm.
// Optional speaker tone is built only when MD_SPEAKER_EN is defined.
module md_frame_sequencer #(
   parameter int H_ACTIVE    = 800,
   parameter int H_BLANK     = 256,
   parameter int V_ACTIVE    = 480,
   parameter int V_BLANK     = 45,
   parameter int ROI_X0      = 20,
   parameter int ROI_X1      = 780,
   parameter int ROI_Y0      = 20,
   parameter int ROI_Y1      = 460,
   parameter int DET_LAT     = 7,
   parameter int CNT_THRESH  = 64,
   parameter int HOLD_FRAMES = 30,
   parameter int TONE_DIV    = 2048
) (
   input  logic                 LCD_CTRL_CLK,
   input  logic                 iRST_N,
   md_frame_sequencer_if.master bus
);

   localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
   localparam logic [10:0] H_BLK_LAST = 11'(H_BLANK - 1);
   localparam logic [10:0] H_TOT_LAST = 11'(H_ACTIVE + H_BLANK - 1);
   localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
   localparam logic [9:0]  V_BLK_LAST = 10'(V_BLANK - 1);
   localparam logic [10:0] EVAL_CYC   = 11'(DET_LAT + 1);
   localparam logic [10:0] ROI_X0_C   = 11'(ROI_X0);
   localparam logic [10:0] ROI_X1_C   = 11'(ROI_X1);
   localparam logic [9:0]  ROI_Y0_C   = 10'(ROI_Y0);
   localparam logic [9:0]  ROI_Y1_C   = 10'(ROI_Y1);
   localparam logic [18:0] THRESH     = 19'(CNT_THRESH);
   localparam logic [7:0]  HOLD_LOAD  = 8'(HOLD_FRAMES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2,
      HBLANK = 2'd3
   } seqState_t;

   seqState_t          state, stateNext;
   logic [10:0]        hCnt, hNext;
   logic [9:0]         vCnt, vNext;
   logic               evalArmed, evalArmedNext;
   logic               evalNow;
   logic               roiNext;
   logic [DET_LAT-1:0] roiPipe;
   logic               roiD;
   logic [18:0]        hitCnt;
   logic [7:0]         hold, holdNext;

   // hCnt counts cycles within the current line segment; vCnt is the blank
   // line index in VBLANK and the active row in ACTIVE/HBLANK.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      stateNext     = state;
      hNext         = hCnt;
      vNext         = vCnt;
      evalArmedNext = evalArmed;
      evalNow       = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.iENABLE) begin
               stateNext = VBLANK;
               hNext     = '0;
               vNext     = '0;
            end
         end

         VBLANK: begin
            evalNow = evalArmed && (vCnt == '0) && (hCnt == EVAL_CYC);
            if (evalNow) evalArmedNext = 1'b0;
            if (hCnt == H_TOT_LAST) begin
               hNext = '0;
               if (vCnt == V_BLK_LAST) begin
                  vNext     = '0;
                  stateNext = bus.iENABLE ? ACTIVE : IDLE;
               end else begin
                  vNext = vCnt + 10'd1;
               end
            end else begin
               hNext = hCnt + 11'd1;
            end
         end

         ACTIVE: begin
            if (hCnt == H_ACT_LAST) begin
               stateNext = HBLANK;
               hNext     = '0;
            end else begin
               hNext = hCnt + 11'd1;
            end
         end

         HBLANK: begin
            if (hCnt == H_BLK_LAST) begin
               hNext = '0;
               if (vCnt == V_ACT_LAST) begin
                  // Only a completed frame arms the evaluation in the next VBLANK.
                  stateNext     = VBLANK;
                  vNext         = '0;
                  evalArmedNext = 1'b1;
               end else begin
                  stateNext = ACTIVE;
                  vNext     = vCnt + 10'd1;
               end
            end else begin
               hNext = hCnt + 11'd1;
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   assign roiNext = (stateNext == ACTIVE) &&
                    (hNext >= ROI_X0_C) && (hNext < ROI_X1_C) &&
                    (vNext >= ROI_Y0_C) && (vNext < ROI_Y1_C);

   assign roiD = roiPipe[DET_LAT-1];

   always_comb begin
      holdNext = hold;
      if (evalNow) begin
         if (hitCnt >= THRESH)  holdNext = HOLD_LOAD;
         else if (hold != '0)   holdNext = hold - 8'd1;
      end
   end

   // Outputs are loaded from next-state values so oX/oY/oROI/oFRAME_START
   // change on the same edge that raises oRead.
   always_ff @(posedge LCD_CTRL_CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state            <= IDLE;
         hCnt             <= '0;
         vCnt             <= '0;
         evalArmed        <= 1'b0;
         bus.oRead        <= 1'b0;
         bus.oX           <= '0;
         bus.oY           <= '0;
         bus.oROI         <= 1'b0;
         bus.oFRAME_START <= 1'b0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
         state            <= stateNext;
         hCnt             <= hNext;
         vCnt             <= vNext;
         evalArmed        <= evalArmedNext;
         bus.oRead        <= (stateNext == ACTIVE);
         bus.oROI         <= roiNext;
         bus.oFRAME_START <= (stateNext == ACTIVE) && (hNext == '0) && (vNext == '0);
         if (stateNext == ACTIVE) begin
            bus.oX <= hNext;
            bus.oY <= vNext;
         end
      end
   end

   // roiPipe[k] holds oROI from k+1 cycles ago, so roiD lines up with iMOTION.
   always_ff @(posedge LCD_CTRL_CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         // NOTE: the ROI pipe is reset as well; stale taps would count phantom hits after a mid-frame reset.
         roiPipe <= '0;
      end else begin
         roiPipe[0] <= bus.oROI;
         for (int i = 1; i < DET_LAT; i++) roiPipe[i] <= roiPipe[i-1];
      end
   end

   always_ff @(posedge LCD_CTRL_CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         hitCnt          <= '0;
         hold            <= '0;
         bus.oMOTION_CNT <= '0;
         bus.oCNT_VLD    <= 1'b0;
         bus.oALARM      <= 1'b0;
      end else begin
         bus.oCNT_VLD <= evalNow;
         hold         <= holdNext;
         bus.oALARM   <= (holdNext != '0);
         // A hit coinciding with evaluation is dropped along with the clear.
         if (evalNow) begin
            bus.oMOTION_CNT <= hitCnt;
            hitCnt          <= '0;
         end else if (roiD && bus.iMOTION) begin
            hitCnt <= hitCnt + 19'd1;
         end
      end
   end

`ifdef MD_SPEAKER_EN
   localparam int                TONE_W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

   logic [TONE_W-1:0] toneCnt;
   logic              tone;

   always_ff @(posedge LCD_CTRL_CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         toneCnt <= '0;
         tone    <= 1'b0;
      end else if (toneCnt == TONE_LAST) begin
         toneCnt <= '0;
         tone    <= ~tone;
      end else begin
         toneCnt <= toneCnt + 1'b1;
      end
   end

   assign bus.oSPK = tone & bus.oALARM;
`else
   logic unusedToneCfg;
   assign unusedToneCfg = (TONE_DIV > 1);
   assign bus.oSPK      = 1'b0;
`endif

endmodule
